// File: rtl/fifo_sc_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy and status flags.
// Drives an external dual-port RAM; optional lookahead read addressing.
module fifo_sc_ctrl #(
  parameter int AWIDTH    = 3,
  parameter int AF_LVL    = 6,
  parameter int AE_LVL    = 2,
  parameter int SHOWAHEAD = 0
) (
  input  logic              clk_i,
  input  logic              aclr_i,
  input  logic              srst_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  output logic              rd_en_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] ZERO = '0;
  localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W = (AWIDTH+1)'(AF_LVL);
  localparam logic [AWIDTH:0] AE_W = (AWIDTH+1)'(AE_LVL);

  logic [AWIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0] usedw_q, usedw_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            aempty_q, aempty_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            wr_acc, rd_acc;
  logic [AWIDTH:0] rd_ptr_inc;

  // Accepts use registered flags; any reset discards the request.
  always_comb begin
    wr_acc = wr_req_i & ~full_q & ~aclr_i & ~srst_i;
    rd_acc = rd_req_i & ~empty_q & ~aclr_i & ~srst_i;
  end

  // Next-state pointers, occupancy, flags and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (srst_i) begin
      wr_ptr_d = ZERO;
      rd_ptr_d = ZERO;
      usedw_d  = ZERO;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + ONE;
        2'b01:   usedw_d = usedw_q - ONE;
        default: usedw_d = usedw_q;
      endcase
      ovf_d = wr_req_i & full_q;
      unf_d = rd_req_i & empty_q;
    end
    empty_d  = (usedw_d == ZERO);
    full_d   = (usedw_d == CNT_FULL);
    aempty_d = (usedw_d <= AE_W);
    afull_d  = (usedw_d >= AF_W);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      usedw_q  <= ZERO;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Lookahead mode pre-fetches the next word on a read accept.
  always_comb begin
    rd_ptr_inc = rd_ptr_q + ONE;
    if (SHOWAHEAD != 0 && rd_acc) rd_addr_o = rd_ptr_inc[AWIDTH-1:0];
    else                          rd_addr_o = rd_ptr_q[AWIDTH-1:0];
  end

  assign wr_en_o        = wr_acc;
  assign rd_en_o        = rd_acc;
  assign wr_addr_o      = wr_ptr_q[AWIDTH-1:0];
  assign usedw_o        = usedw_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
